// File: rtl/bf_norm_round_stage.sv
// BF16 FMA post-adder stage: EAC sign recovery and leading-zero count (S1),
// then normalize, round-to-nearest-even and pack (S2), with valid/ready flow control.
module bf_norm_round_stage #(
  parameter int unsigned ADDER_WIDTH = 24,
  parameter int unsigned EXP_WIDTH   = 8,
  parameter int unsigned MAN_WIDTH   = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDER_WIDTH-1:0]         in_sum,
  input  logic                           in_cout,
  input  logic                           in_sign,
  input  logic [EXP_WIDTH+1:0]           in_exp,
  input  logic                           in_sticky,
  input  logic                           in_eff_sub,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   out_result,
  output logic                           out_overflow,
  output logic                           out_underflow,
  output logic                           out_inexact
);

  localparam int unsigned W  = ADDER_WIDTH;
  localparam int unsigned LW = $clog2(ADDER_WIDTH + 1);
  localparam int unsigned XW = EXP_WIDTH + 4;
  localparam int unsigned KW = MAN_WIDTH + 1;
  localparam int unsigned RB = W - KW - 2;

  localparam logic signed [XW-1:0] EXP_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] EXP_MAX = {4'b0000, {EXP_WIDTH{1'b1}}};

  // ---------------- flow control ----------------
  logic s1_valid;
  logic s2_can_load;
  logic s1_load;

  assign s2_can_load = ~out_valid | out_ready;
  assign in_ready    = ~s1_valid | s2_can_load;
  assign s1_load     = in_valid & in_ready;

  // in_ready implies S1 is either empty or advancing this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // ---------------- S1: sign recovery + LZC ----------------
  logic [W-1:0]          s1_mag_d;
  logic signed [XW-1:0]  s1_exp_d;
  logic                  s1_sign_d;
  logic                  s1_sticky_d;
  logic                  s1_zero_d;
  logic [LW-1:0]         s1_lzc_d;

  always_comb begin
    s1_mag_d    = in_sum;
    s1_exp_d    = {{2{in_exp[EXP_WIDTH+1]}}, in_exp};
    s1_sign_d   = in_sign;
    s1_sticky_d = in_sticky;
    if (!in_eff_sub && in_cout) begin
      s1_mag_d    = {1'b1, in_sum[W-1:1]};
      s1_exp_d    = s1_exp_d + EXP_ONE;
      s1_sticky_d = in_sticky | in_sum[0];
    end else if (in_eff_sub && !in_cout) begin
      // no end-around carry: result is negative, magnitude is the complement
      s1_mag_d  = ~in_sum;
      s1_sign_d = ~in_sign;
    end
    s1_lzc_d = LW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (s1_mag_d[i]) s1_lzc_d = LW'(W - 1 - i);
    end
    s1_zero_d = (s1_mag_d == '0) && !s1_sticky_d;
  end

  logic [W-1:0]          s1_mag;
  logic signed [XW-1:0]  s1_exp;
  logic                  s1_sign;
  logic                  s1_sticky;
  logic                  s1_zero;
  logic [LW-1:0]         s1_lzc;

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_mag    <= s1_mag_d;
      s1_exp    <= s1_exp_d;
      s1_sign   <= s1_sign_d;
      s1_sticky <= s1_sticky_d;
      s1_zero   <= s1_zero_d;
      s1_lzc    <= s1_lzc_d;
    end
  end

  // ---------------- S2: normalize + RNE + pack ----------------
  logic [W-1:0]                  norm;
  logic [KW-1:0]                 kept;
  logic                          g_bit;
  logic                          r_bit;
  logic                          s_bit;
  logic                          inc;
  logic [KW:0]                   rnd;
  logic signed [XW-1:0]          exp_n;
  logic signed [XW-1:0]          exp_r;
  logic [EXP_WIDTH+MAN_WIDTH:0]  res_d;
  logic                          ovf_d;
  logic                          unf_d;
  logic                          inx_d;

  always_comb begin
    norm  = s1_mag << s1_lzc;
    kept  = norm[W-1 -: KW];
    g_bit = norm[W-1-KW];
    r_bit = norm[W-2-KW];
    s_bit = (|norm[RB-1:0]) | s1_sticky;
    inc   = g_bit & (r_bit | s_bit | kept[0]);
    rnd   = {1'b0, kept} + {{KW{1'b0}}, inc};
    exp_n = s1_exp - {{(XW-LW){1'b0}}, s1_lzc};
    exp_r = rnd[KW] ? exp_n + EXP_ONE : exp_n;
    inx_d = g_bit | r_bit | s_bit;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    // on mantissa carry-out the low fraction bits of rnd are already zero
    res_d = {s1_sign, exp_r[EXP_WIDTH-1:0], rnd[MAN_WIDTH-1:0]};
    if (s1_zero) begin
      res_d = '0;
      inx_d = 1'b0;
    end else if (exp_r >= EXP_MAX) begin
      res_d = {s1_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_r[XW-1] || (exp_r == '0) || (s1_mag == '0)) begin
      res_d = {s1_sign, {(EXP_WIDTH+MAN_WIDTH){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_can_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= res_d;
        out_overflow  <= ovf_d;
        out_underflow <= unf_d;
        out_inexact   <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_bf_norm_round_stage.sv
// Table-driven bench for bf_norm_round_stage; expected results queued on accept,
// compared on every cycle the DUT presents a result.
`timescale 1ns/1ps
module tb_bf_norm_round_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_sum = '0;
  logic        in_cout = 1'b0;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic        in_sticky = 1'b0;
  logic        in_eff_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  always #5 clk = ~clk;

  bf_norm_round_stage #(
    .ADDER_WIDTH(24),
    .EXP_WIDTH  (8),
    .MAN_WIDTH  (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_cout      (in_cout),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_sticky    (in_sticky),
    .in_eff_sub   (in_eff_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_inexact  (out_inexact)
  );

  typedef struct {
    logic        sub;
    logic [23:0] sum;
    logic        cout;
    logic        sign;
    logic [9:0]  exp;
    logic        sticky;
    logic [15:0] res;
    logic [2:0]  flg;   // {overflow, underflow, inexact}
  } vec_t;

  localparam int NV = 15;
  vec_t tbl[NV];
  int   q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  logic mon_en   = 1'b0;
  int   rdy_mode = 0;

  function automatic vec_t mk(input logic sub, input logic [23:0] sum, input logic cout,
                              input logic sign, input logic [9:0] exp, input logic sticky,
                              input logic [15:0] res, input logic [2:0] flg);
    vec_t v;
    v.sub = sub; v.sum = sum; v.cout = cout; v.sign = sign;
    v.exp = exp; v.sticky = sticky; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // out_ready: 0 = always 1, 1 = repeating 1,0,0,1, otherwise random
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  // scoreboard: while a result is shown it must match the queue head, even when stalled
  always begin : monitor
    int k;
    @(negedge clk);
    #2;
    if (mon_en && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        k = q[0];
        chk($sformatf("v%0d_result", k), 32'(out_result), 32'(tbl[k].res));
        chk($sformatf("v%0d_flags", k), 32'({out_overflow, out_underflow, out_inexact}),
            32'(tbl[k].flg));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input int k);
    int n;
    n = 0;
    @(negedge clk);
    in_eff_sub = tbl[k].sub;
    in_sum     = tbl[k].sum;
    in_cout    = tbl[k].cout;
    in_sign    = tbl[k].sign;
    in_exp     = tbl[k].exp;
    in_sticky  = tbl[k].sticky;
    in_valid   = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (in_ready) q.push_back(k);
    else chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(q.size()), 32'd0);
    @(negedge clk);
    #3;
    chk({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            sub  sum          c     sg    exp      st    result    {ov,uf,ix}
    tbl[0]  = mk(1'b0, 24'h000000, 1'b1, 1'b0, 10'd127, 1'b0, 16'h4000, 3'b000);
    tbl[1]  = mk(1'b1, 24'h400000, 1'b1, 1'b0, 10'd127, 1'b0, 16'h3F00, 3'b000);
    tbl[2]  = mk(1'b1, 24'hBFFFFF, 1'b0, 1'b0, 10'd127, 1'b0, 16'hBF00, 3'b000);
    tbl[3]  = mk(1'b1, 24'h000000, 1'b1, 1'b0, 10'd127, 1'b0, 16'h0000, 3'b000);
    tbl[4]  = mk(1'b0, 24'h80C000, 1'b0, 1'b0, 10'd127, 1'b0, 16'h3F81, 3'b001);
    tbl[5]  = mk(1'b0, 24'h818000, 1'b0, 1'b0, 10'd127, 1'b0, 16'h3F82, 3'b001);
    tbl[6]  = mk(1'b0, 24'h808000, 1'b0, 1'b0, 10'd127, 1'b0, 16'h3F80, 3'b001);
    tbl[7]  = mk(1'b0, 24'h000000, 1'b1, 1'b0, 10'd254, 1'b0, 16'h7F80, 3'b101);
    tbl[8]  = mk(1'b1, 24'h400000, 1'b1, 1'b0, 10'd1,   1'b0, 16'h0000, 3'b011);
    tbl[9]  = mk(1'b0, 24'hFFFFFF, 1'b0, 1'b1, 10'd127, 1'b0, 16'hC000, 3'b001);
    tbl[10] = mk(1'b0, 24'h000001, 1'b1, 1'b0, 10'd127, 1'b0, 16'h4000, 3'b001);
    tbl[11] = mk(1'b0, 24'hFFFFFF, 1'b1, 1'b0, 10'd253, 1'b0, 16'h7F80, 3'b101);
    tbl[12] = mk(1'b0, 24'h800000, 1'b0, 1'b0, 10'd254, 1'b0, 16'h7F00, 3'b000);
    tbl[13] = mk(1'b1, 24'h400000, 1'b1, 1'b0, 10'd2,   1'b0, 16'h0080, 3'b000);
    tbl[14] = mk(1'b1, 24'hFFFFFF, 1'b0, 1'b0, 10'd127, 1'b0, 16'h0000, 3'b000);

    // reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_flags", 32'({out_overflow, out_underflow, out_inexact}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // every table vector, back-to-back, downstream always ready
    rdy_mode = 0;
    for (int k = 0; k < NV; k++) send(k);
    idle();
    drain("table");

    // 8 back-to-back inputs with out_ready cycling 1,0,0,1
    rdy_mode = 1;
    for (int k = 0; k < 8; k++) send(k);
    idle();
    drain("flow");

    // random order, random gaps, random backpressure
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      send(int'($urandom_range(0, NV - 1)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rdy_mode = 0;
    drain("random");

    // reset with both pipeline entries occupied
    rdy_mode = 0;
    send(4);
    send(5);
    send(6);
    @(negedge clk);
    mon_en   = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b1;
    q.delete();
    @(negedge clk);
    #3;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("midrst_no_partial_1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #3;
    chk("midrst_no_partial_2", 32'(out_valid), 32'd0);
    mon_en = 1'b1;
    send(9);
    idle();
    drain("recover");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
